// File: rtl/wb_burst_master_if.sv
// wb_burst_master_if: command, write/read streams and Wishbone pipelined bus
// for wb_burst_master. The master modport is the DUT view; slave is the
// view of whoever drives commands and models the bus slave.
interface wb_burst_master_if #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_stall_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len, wr_data, wr_valid,
           wb_dat_i, wb_ack_i, wb_stall_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len, wr_data, wr_valid,
           wb_dat_i, wb_ack_i, wb_stall_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// wb_burst_master: pipelined Wishbone (STALL-capable) burst master.
// One command becomes a burst of single-word STB transfers with up to MAXOUT
// transfers in flight. Write words come from the wr_* stream, read words leave
// on rd_* (no backpressure).
// Optional feature: define WB_BURST_TIMEOUT_EN to add an ack watchdog that
// aborts the burst after TIMEOUT cycles without an ack (err pulses with done).
module wb_burst_master #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MAXLEN  = 16,
  parameter int MAXOUT  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_burst_master_if.master bus
);
  localparam int LW = $clog2(MAXLEN + 1);
  localparam int OW = $clog2(MAXOUT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;

  logic [0:0]    r_state;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [LW-1:0] r_issue_cnt;
  logic [OW-1:0] r_out;
  logic          r_done;
  logic          r_err;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;

  logic w_cyc;
  logic w_stb;
  logic w_issue;
  logic w_ack;
  logic w_last;
  logic w_accept;
  logic w_tmo;

  // cyc follows the state register, so an async reset drops it immediately.
  // stb is purely combinational on registered counters plus wr_valid; while
  // stalled none of those move, so stb/adr/dat hold by construction.
  assign w_cyc    = (r_state == S_BUS);
  assign w_stb    = w_cyc && (r_issue_cnt != '0) && (r_out < OW'(MAXOUT)) &&
                    (!r_we || bus.wr_valid);
  assign w_issue  = w_stb && !bus.wb_stall_i;
  assign w_ack    = w_cyc && bus.wb_ack_i && (r_out != '0);
  assign w_last   = w_ack && (r_issue_cnt == '0) && (r_out == OW'(1));
  assign w_accept = bus.cmd_valid && !w_cyc;

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Watchdog: cleared by any ack, counts only while transfers are un-acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo_cnt <= '0;
    else if (!w_cyc || w_ack)
      r_tmo_cnt <= '0;
    else if ((r_out != '0) && (r_tmo_cnt != TW'(TIMEOUT)))
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  // An ack in the expiry cycle wins over the abort.
  assign w_tmo = w_cyc && !w_ack && (r_tmo_cnt == TW'(TIMEOUT));
`else
  assign w_tmo = 1'b0;
`endif

  // Burst control: command latch, issue/ack bookkeeping, completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_issue_cnt <= '0;
      r_out       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_ack && !r_we) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= bus.wb_dat_i;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.cmd_we;
            r_adr       <= bus.cmd_adr;
            r_issue_cnt <= bus.cmd_len;
            r_out       <= '0;
            // A zero-length command completes without touching the bus.
            if (bus.cmd_len == '0)
              r_done <= 1'b1;
            else
              r_state <= S_BUS;
          end
        end
        default: begin
          if (w_issue) begin
            r_adr       <= r_adr + AW'(1);
            r_issue_cnt <= r_issue_cnt - LW'(1);
          end
          case ({w_issue, w_ack})
            2'b10:   r_out <= r_out + OW'(1);
            2'b01:   r_out <= r_out - OW'(1);
            default: r_out <= r_out;
          endcase
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = !w_cyc;
  assign bus.wr_ready  = w_issue && r_we;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.wb_cyc_o  = w_cyc;
  assign bus.wb_stb_o  = w_stb;
  assign bus.wb_we_o   = w_cyc && r_we;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_dat_o  = bus.wr_data;
endmodule
